// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART 8N1 transmitter.
package fifo_uart_tx_pkg;

    // Number of data bits per UART frame (8N1).
    localparam int unsigned UART_DATA_BITS = 8;

    // Transmitter states, fixed 3-bit encoding.
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StPop   = 3'd1,
        StLoad  = 3'd2,
        StStart = 3'd3,
        StData  = 3'd4,
        StStop  = 3'd5
    } tx_state_e;

    // Ceiling log2, used to size counters; returns 1 for values below 3.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        int unsigned rem;
        width = 0;
        rem   = (value > 0) ? value - 1 : 0;
        for (int i = 0; i < 32; i++) begin
            if (rem != 0) begin
                width = width + 1;
                rem   = rem >> 1;
            end
        end
        if (width == 0) begin
            width = 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the
// last cycle of each bit period. Usable by both TX and RX sides of a UART.
module uart_baud_cnt #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned CNT_W        = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_bit_end
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_last;

    assign w_at_last = (r_cnt == LAST_CNT);
    assign o_cnt     = r_cnt;
    assign o_bit_end = i_en && w_at_last;

    // Clear has priority; otherwise count and wrap at each bit boundary.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_at_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// Pops bytes from the on-chip byte FIFO (1-cycle read latency) and sends each
// as UART 8N1, LSB first. All outputs come straight from flops.
module fifo_uart_tx
    import fifo_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 24000000,
    parameter int unsigned BAUD     = 115200
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_enable,
    input  logic                      i_fifo_empty,
    input  logic [UART_DATA_BITS-1:0] i_fifo_do,
    output logic                      o_fifo_re,
    output logic                      o_uart_tx,
    output logic                      o_busy,
    output logic                      o_byte_done
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int unsigned CNT_W        = clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W        = clog2(UART_DATA_BITS);

    localparam logic [IDX_W-1:0] LAST_BIT      = IDX_W'(UART_DATA_BITS - 1);
    // byte_done is registered, so it is armed one cycle before the stop bit ends.
    localparam logic [CNT_W-1:0] DONE_ARM_CNT  = CNT_W'(CLKS_PER_BIT - 2);

    if (CLKS_PER_BIT < 4) begin : g_bad_baud
        $error("fifo_uart_tx: CLK_FREQ/BAUD must be at least 4");
    end

    tx_state_e                 r_state;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic [IDX_W-1:0]          r_bit_idx;
    logic                      r_tx;
    logic                      r_fifo_re;
    logic                      r_busy;
    logic                      r_byte_done;

    logic                      w_cnt_en;
    logic                      w_bit_end;
    logic [CNT_W-1:0]          w_cnt;

    // Baud counter runs only while a bit is on the line; held at 0 otherwise.
    always_comb begin
        w_cnt_en = 1'b0;
        if (r_state == StStart || r_state == StData || r_state == StStop) begin
            w_cnt_en = 1'b1;
        end
    end

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_baud_cnt (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (!w_cnt_en),
        .i_en     (w_cnt_en),
        .o_cnt    (w_cnt),
        .o_bit_end(w_bit_end)
    );

    // Frame FSM; line level and strobes are updated on the same edge as the
    // state so every output lines up exactly with its state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_shift     <= '0;
            r_bit_idx   <= '0;
            r_tx        <= 1'b1;
            r_fifo_re   <= 1'b0;
            r_busy      <= 1'b0;
            r_byte_done <= 1'b0;
        end else begin
            r_fifo_re   <= 1'b0;
            r_byte_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_enable && !i_fifo_empty) begin
                        r_state   <= StPop;
                        r_fifo_re <= 1'b1;
                        r_busy    <= 1'b1;
                    end
                end
                StPop: begin
                    r_state <= StLoad;
                end
                StLoad: begin
                    // FIFO read data is valid now, one cycle after the strobe.
                    r_shift   <= i_fifo_do;
                    r_bit_idx <= '0;
                    r_tx      <= 1'b0;
                    r_state   <= StStart;
                end
                StStart: begin
                    if (w_bit_end) begin
                        r_tx    <= r_shift[0];
                        r_state <= StData;
                    end
                end
                StData: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= StStop;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                            r_shift   <= {1'b0, r_shift[UART_DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                        end
                    end
                end
                StStop: begin
                    if (w_cnt == DONE_ARM_CNT) begin
                        r_byte_done <= 1'b1;
                    end
                    if (w_bit_end) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_uart_tx   = r_tx;
    assign o_fifo_re   = r_fifo_re;
    assign o_busy      = r_busy;
    assign o_byte_done = r_byte_done;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx with a 1-cycle-latency FIFO model and a
// line-level monitor that compares every frame against a scoreboard queue.
module tb_fifo_uart_tx;

    localparam int CPB   = 16;
    localparam int FRAME = 10 * CPB;

    logic       clk        = 1'b0;
    logic       rst_n      = 1'b1;
    logic       enable     = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_do    = 8'h00;
    logic       fifo_re;
    logic       uart_tx;
    logic       busy;
    logic       byte_done;

    logic [7:0] fifo_q[$];
    logic [9:0] exp_q[$];
    int         low_q[$];
    int         gap_q[$];

    int total          = 0;
    int bad            = 0;
    int cyc            = 0;
    int re_count       = 0;
    int done_count     = 0;
    int re_empty_viol  = 0;
    int frames_started = 0;
    int frames_done    = 0;
    int frames_aborted = 0;
    int last_end_cyc   = -1000;

    typedef struct {
        logic [7:0] din;
        logic [9:0] frame;  // {stop, d7..d0, start}
    } vec_t;

    vec_t vecs[6];

    fifo_uart_tx #(
        .CLK_FREQ(1600),
        .BAUD    (100)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_enable    (enable),
        .i_fifo_empty(fifo_empty),
        .i_fifo_do   (fifo_do),
        .o_fifo_re   (fifo_re),
        .o_uart_tx   (uart_tx),
        .o_busy      (busy),
        .o_byte_done (byte_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_re && fifo_q.size() > 0) fifo_do <= fifo_q.pop_front();
    end

    always @(negedge clk) fifo_empty <= (fifo_q.size() == 0);

    always @(negedge clk) begin
        if (fifo_re) re_count++;
        if (byte_done) done_count++;
        if (fifo_re && fifo_empty) re_empty_viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d, input logic [9:0] f);
        fifo_q.push_back(d);
        exp_q.push_back(f);
    endtask

    task automatic wait_events(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (frames_done + frames_aborted < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(frames_done + frames_aborted >= target), 32'd1);
    endtask

    task automatic wait_start(input int target, input int budget, input string name);
        int k;
        k = 0;
        while (frames_started < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(name, 32'(frames_started >= target), 32'd1);
    endtask

    // Line monitor: captures each frame cycle by cycle from its start bit.
    initial begin : monitor
        logic [9:0] exp_f;
        logic [7:0] got;
        int         bad_cyc;
        int         low_run;
        logic       still_low;
        logic       aborted;
        logic       exp_lvl;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                frames_started++;
                gap_q.push_back(cyc - last_end_cyc - 1);
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                    exp_f = 10'h3ff;
                end else begin
                    exp_f = exp_q.pop_front();
                end
                got       = 8'h00;
                bad_cyc   = 0;
                low_run   = 0;
                still_low = 1'b1;
                aborted   = 1'b0;
                for (int c = 0; c < FRAME; c++) begin
                    if (c > 0) @(negedge clk);
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    exp_lvl = exp_f[c / CPB];
                    if (uart_tx !== exp_lvl || busy !== 1'b1 ||
                        byte_done !== (c == FRAME - 1)) begin
                        bad_cyc++;
                    end
                    if (c % CPB == CPB / 2 && c / CPB >= 1 && c / CPB <= 8) begin
                        got[c / CPB - 1] = uart_tx;
                    end
                    if (still_low && uart_tx === 1'b0) low_run++;
                    else still_low = 1'b0;
                end
                if (aborted) begin
                    frames_aborted++;
                end else begin
                    check("frame_cycles", 32'(bad_cyc), 32'd0);
                    check("frame_data", {24'd0, got}, {24'd0, exp_f[8:1]});
                    low_q.push_back(low_run);
                    last_end_cyc = cyc;
                    frames_done++;
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int ev;
        int re0;
        int d0;
        int n_low;
        int n_gap;
        int viol;

        vecs[0] = '{din: 8'h3C, frame: 10'b1_00111100_0};
        vecs[1] = '{din: 8'h81, frame: 10'b1_10000001_0};
        vecs[2] = '{din: 8'h55, frame: 10'b1_01010101_0};
        vecs[3] = '{din: 8'h01, frame: 10'b1_00000001_0};
        vecs[4] = '{din: 8'h80, frame: 10'b1_10000000_0};
        vecs[5] = '{din: 8'hE7, frame: 10'b1_11100111_0};

        // Reset held with a byte waiting; nothing may move.
        #1 rst_n = 1'b0;
        enable = 1'b1;
        push_byte(8'hA5, 10'b1_10100101_0);
        viol = 0;
        repeat (5) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || fifo_re !== 1'b0 || busy !== 1'b0 || byte_done !== 1'b0)
                viol++;
        end
        check("reset_outputs", 32'(viol), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("first_re", {31'd0, fifo_re}, 32'd1);
        check("first_busy", {31'd0, busy}, 32'd1);

        // Single byte 0xA5.
        wait_events(1, 400, "a5_frame_seen");
        repeat (4) @(negedge clk);
        check("a5_re_pulses", 32'(re_count), 32'd1);
        check("a5_done_pulses", 32'(done_count), 32'd1);

        // Table-driven single frames.
        for (int i = 0; i < 6; i++) begin
            ev  = frames_done + frames_aborted;
            re0 = re_count;
            d0  = done_count;
            push_byte(vecs[i].din, vecs[i].frame);
            wait_events(ev + 1, 400, "vec_frame_seen");
            repeat (4) @(negedge clk);
            check("vec_re_pulses", 32'(re_count - re0), 32'd1);
            check("vec_done_pulses", 32'(done_count - d0), 32'd1);
        end

        // Back-to-back 0x00 then 0xFF.
        ev    = frames_done + frames_aborted;
        d0    = done_count;
        n_low = low_q.size();
        n_gap = gap_q.size();
        push_byte(8'h00, 10'b1_00000000_0);
        push_byte(8'hFF, 10'b1_11111111_0);
        wait_events(ev + 2, 800, "b2b_frames_seen");
        repeat (4) @(negedge clk);
        if (low_q.size() >= n_low + 2 && gap_q.size() >= n_gap + 2) begin
            check("b2b_low_00", 32'(low_q[n_low]), 32'd144);
            check("b2b_low_ff", 32'(low_q[n_low + 1]), 32'd16);
            check("b2b_gap", 32'(gap_q[n_gap + 1]), 32'd3);
        end else begin
            check("b2b_records", 32'(low_q.size() - n_low), 32'd2);
        end
        check("b2b_done_pulses", 32'(done_count - d0), 32'd2);

        // Empty FIFO with enable high.
        re0  = re_count;
        viol = 0;
        repeat (500) begin
            @(negedge clk);
            if (fifo_re !== 1'b0 || uart_tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("empty_idle", 32'(viol), 32'd0);
        check("empty_no_re", 32'(re_count - re0), 32'd0);

        // enable dropped mid-DATA of 0x3C with a second byte queued.
        ev  = frames_done + frames_aborted;
        re0 = re_count;
        push_byte(8'h3C, 10'b1_00111100_0);
        push_byte(8'h96, 10'b1_10010110_0);
        wait_start(frames_started + 1, 100, "en_frame_start");
        repeat (40) @(negedge clk);
        enable = 1'b0;
        wait_events(ev + 1, 400, "en_frame_seen");
        repeat (50) @(negedge clk);
        check("en_re_pulses", 32'(re_count - re0), 32'd1);
        check("en_fifo_left", 32'(fifo_q.size()), 32'd1);
        check("en_idle_tx", {31'd0, uart_tx}, 32'd1);
        check("en_idle_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        wait_events(ev + 2, 400, "en_resume_seen");
        repeat (4) @(negedge clk);
        check("en_resume_re", 32'(re_count - re0), 32'd2);
        check("en_fifo_drained", 32'(fifo_q.size()), 32'd0);

        // Reset pulse during data bit 0 (a low bit) of 0x5A.
        ev = frames_done + frames_aborted;
        push_byte(8'h5A, 10'b1_01011010_0);
        push_byte(8'hC3, 10'b1_11000011_0);
        wait_start(frames_started + 1, 100, "rst_frame_start");
        repeat (20) @(negedge clk);
        check("pre_reset_tx", {31'd0, uart_tx}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("async_tx", {31'd0, uart_tx}, 32'd1);
        check("async_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        check("rst_aborted", 32'(frames_aborted), 32'd1);
        rst_n = 1'b1;
        wait_events(ev + 2, 400, "rst_next_frame_seen");
        repeat (4) @(negedge clk);
        check("rst_fifo_drained", 32'(fifo_q.size()), 32'd0);

        // Global invariants.
        check("re_while_empty", 32'(re_empty_viol), 32'd0);
        check("done_vs_frames", 32'(done_count), 32'(frames_done));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
